// File: rtl/rx_frame_pkg.sv
// rtl/rx_frame_pkg.sv - shared token encoding, state enums and helpers for rx_frame_ctrl
//
// Purpose : common definitions for the dual-rail frame receiver controller.
// Contents: TOKEN_N, token bit positions (one-hot), priority picker,
//           handshake and frame state enums.
package rx_frame_pkg;

  localparam int TOKEN_N = 6;

  typedef logic [TOKEN_N-1:0] tok_t;

  // One-hot bit positions in the token vector. The index order is also the
  // priority order: a higher index wins (x0 > fe > fs > fd > one > zero).
  localparam int TOK_ZERO = 0;
  localparam int TOK_ONE  = 1;
  localparam int TOK_FD   = 2;
  localparam int TOK_FS   = 3;
  localparam int TOK_FE   = 4;
  localparam int TOK_X0   = 5;

  typedef enum logic [1:0] {
    H_IDLE,
    H_ACK,
    H_REL
  } h_state_t;

  typedef enum logic {
    F_IDLE,
    F_DATA
  } f_state_t;

  // Highest-priority set bit of req as a one-hot vector (zero if none set).
  function automatic tok_t tok_pick(input tok_t req);
    tok_t w;
    w = '0;
    for (int i = 0; i < TOKEN_N; i++) begin
      if (req[i]) w = tok_t'(1) << i;
    end
    return w;
  endfunction

  // True when more than one token is raised at once.
  function automatic logic tok_multi(input tok_t v);
    return (v & (v - tok_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/rx_sync2.sv
// rtl/rx_sync2.sv - parameterised-width two-flop synchroniser
//
// Purpose : bring asynchronous level signals into the clk domain.
// Ports   : clk   - destination clock
//           rst_n - asynchronous active-low reset (clears both stages)
//           d     - asynchronous input vector, W bits
//           q     - synchronised output vector, W bits
module rx_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - clocked sequencer for the self-timed dual-rail frame receiver
//
// Purpose : synchronises receiver tokens, closes each 4-phase handshake with a
//           registered ack, and assembles MSB-first bits into DATA_W-bit words.
//           Backpressure is applied by withholding the delimiter ack while a
//           word is waiting for the consumer.
// Params  : DATA_W      - word width (2..32)
//           TIMEOUT_CYC - max cycles an ack waits for token release
//                         (used only when RX_ACK_TIMEOUT_EN is defined)
// Macro   : RX_ACK_TIMEOUT_EN - enables the ack-release timeout
// Ports   : clk, reset (async active-low)
//           fs_in/fe_in/fd_in/x0_in/zero_in/one_in       - receiver tokens
//           fs_ack/fe_ack/fd_ack/x0_ack/zero_ack/one_ack - acknowledges
//           word_data/word_valid/word_ready              - word output
//           frame_start/frame_end/frame_err              - single-cycle pulses
//           in_frame                                     - frame open
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fs_in,
  input  logic              fe_in,
  input  logic              fd_in,
  input  logic              x0_in,
  input  logic              zero_in,
  input  logic              one_in,
  output logic              fs_ack,
  output logic              fe_ack,
  output logic              fd_ack,
  output logic              x0_ack,
  output logic              zero_ack,
  output logic              one_ack,
  output logic [DATA_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              frame_start,
  output logic              frame_end,
  output logic              frame_err,
  output logic              in_frame
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  tok_t tok_raw;
  tok_t tok_s;
  tok_t tok_ok;
  tok_t win;
  tok_t ack;

  h_state_t hstate;
  f_state_t fstate;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;

  logic cnt_full;
  logic fd_blocked;
  logic take;
  logic tok_err;

`ifdef RX_ACK_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] tmo_cnt;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC > 0);
`endif

  assign tok_raw = {x0_in, fe_in, fs_in, fd_in, one_in, zero_in};

  rx_sync2 #(.W(TOKEN_N)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (tok_raw),
    .q     (tok_s)
  );

  assign cnt_full   = (cnt == CNT_W'(DATA_W));
  // A delimiter would need to load word_data; hold it off while the current
  // word is still pending and not being taken this cycle.
  assign fd_blocked = word_valid && !word_ready;

  always_comb begin
    tok_ok = tok_s;
    if (fd_blocked) tok_ok[TOK_FD] = 1'b0;
    win  = tok_pick(tok_ok);
    take = (hstate == H_IDLE) && (tok_ok != '0);
  end

  // Protocol error raised by the token being accepted now.
  always_comb begin
    tok_err = tok_multi(tok_s);
    if (fstate == F_IDLE) begin
      if (!win[TOK_FS] && !win[TOK_X0]) tok_err = 1'b1;
    end else begin
      if (win[TOK_X0] || win[TOK_FS])                  tok_err = 1'b1;
      else if (win[TOK_FE] && (cnt != '0))             tok_err = 1'b1;
      else if (win[TOK_FD] && !cnt_full)               tok_err = 1'b1;
      else if ((win[TOK_ONE] || win[TOK_ZERO]) && cnt_full) tok_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hstate      <= H_IDLE;
      fstate      <= F_IDLE;
      ack         <= '0;
      cnt         <= '0;
      shreg       <= '0;
      word_data   <= '0;
      word_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
`ifdef RX_ACK_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
      // A word loaded further down in this same cycle overrides this clear.
      if (word_valid && word_ready) word_valid <= 1'b0;

      case (hstate)
        H_IDLE: begin
`ifdef RX_ACK_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          if (take) begin
            ack       <= win;
            hstate    <= H_ACK;
            frame_err <= tok_err;
            if (fstate == F_IDLE) begin
              // Only Fs opens a frame; everything else is acked and dropped.
              if (win[TOK_FS]) begin
                fstate      <= F_DATA;
                cnt         <= '0;
                frame_start <= 1'b1;
              end
            end else begin
              if (win[TOK_X0]) begin
                fstate <= F_IDLE;
                cnt    <= '0;
              end else if (win[TOK_FE]) begin
                frame_end <= 1'b1;
                fstate    <= F_IDLE;
                cnt       <= '0;
              end else if (win[TOK_FS]) begin
                frame_start <= 1'b1;
                cnt         <= '0;
              end else if (win[TOK_FD]) begin
                if (cnt_full) begin
                  word_data  <= shreg;
                  word_valid <= 1'b1;
                end
                cnt <= '0;
              end else if (!cnt_full) begin
                shreg <= {shreg[DATA_W-2:0], win[TOK_ONE]};
                cnt   <= cnt + 1'b1;
              end
            end
          end
        end

        H_ACK: begin
          if (tok_s == '0) begin
            ack    <= '0;
            hstate <= H_REL;
          end
`ifdef RX_ACK_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            // Receiver never released its token: give up on the frame.
            ack       <= '0;
            frame_err <= 1'b1;
            fstate    <= F_IDLE;
            cnt       <= '0;
            hstate    <= H_REL;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
`endif
        end

        H_REL: hstate <= H_IDLE;

        default: hstate <= H_IDLE;
      endcase
    end
  end

  assign zero_ack = ack[TOK_ZERO];
  assign one_ack  = ack[TOK_ONE];
  assign fd_ack   = ack[TOK_FD];
  assign fs_ack   = ack[TOK_FS];
  assign fe_ack   = ack[TOK_FE];
  assign x0_ack   = ack[TOK_X0];
  assign in_frame = (fstate == F_DATA);

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - self-checking bench for rx_frame_ctrl
module tb_rx_frame_ctrl;

  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 16;

  localparam logic [5:0] T_Z = 6'b000001;
  localparam logic [5:0] T_O = 6'b000010;
  localparam logic [5:0] T_D = 6'b000100;
  localparam logic [5:0] T_S = 6'b001000;
  localparam logic [5:0] T_E = 6'b010000;
  localparam logic [5:0] T_X = 6'b100000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] tok = '0;
  logic fs_in, fe_in, fd_in, x0_in, zero_in, one_in;
  logic fs_ack, fe_ack, fd_ack, x0_ack, zero_ack, one_ack;
  logic [DATA_W-1:0] word_data;
  logic word_valid;
  logic word_ready = 1'b1;
  logic frame_start, frame_end, frame_err, in_frame;
  logic [5:0] ackv;

  assign {x0_in, fe_in, fs_in, fd_in, one_in, zero_in} = tok;
  assign ackv = {x0_ack, fe_ack, fs_ack, fd_ack, one_ack, zero_ack};

  always #5 clk = ~clk;

  rx_frame_ctrl #(.DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset),
    .fs_in(fs_in), .fe_in(fe_in), .fd_in(fd_in), .x0_in(x0_in),
    .zero_in(zero_in), .one_in(one_in),
    .fs_ack(fs_ack), .fe_ack(fe_ack), .fd_ack(fd_ack), .x0_ack(x0_ack),
    .zero_ack(zero_ack), .one_ack(one_ack),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .frame_start(frame_start), .frame_end(frame_end), .frame_err(frame_err),
    .in_frame(in_frame)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int c_fs = 0, c_fe = 0, c_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pulse counters and word scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_start) c_fs++;
      if (frame_end)   c_fe++;
      if (frame_err)   c_err++;
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL word_unexpected: got %0h expected no word", word_data);
        end else begin
          check("word_data", word_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic raise(input logic [5:0] tv);
    @(posedge clk);
    #1 tok = tv;
  endtask

  task automatic wait_ack(input string nm, output logic [5:0] got);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ackv != '0) seen = 1;
    end
    got = ackv;
    check({nm, "_ack_seen"}, seen, 1);
  endtask

  task automatic release_tok(input string nm);
    bit gone = 0;
    @(posedge clk);
    #1 tok = '0;
    for (int i = 0; i < 20 && !gone; i++) begin
      @(negedge clk);
      if (ackv == '0) gone = 1;
    end
    check({nm, "_ack_fall"}, gone, 1);
    @(negedge clk);
  endtask

  task automatic hs(input logic [5:0] tv, input string nm, output logic [5:0] got);
    raise(tv);
    wait_ack(nm, got);
    release_tok(nm);
  endtask

  typedef struct {
    logic [5:0] tv;
    logic [5:0] ack;
    int         fs, fe, err;
    logic       inf;
    bit         push;
    logic [7:0] word;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic [5:0] tv, input logic [5:0] ack,
                              input int fs, input int fe, input int err,
                              input logic inf, input bit push, input logic [7:0] word);
    vec_t v;
    v.tv = tv; v.ack = ack; v.fs = fs; v.fe = fe; v.err = err;
    v.inf = inf; v.push = push; v.word = word;
    vt.push_back(v);
  endfunction

  function automatic void add_bits(input logic [7:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (val[i]) add(T_O, T_O, 0, 0, 0, 1'b1, 0, 8'h00);
      else        add(T_Z, T_Z, 0, 0, 0, 1'b1, 0, 8'h00);
    end
  endfunction

  initial begin #400000; $display("FAIL watchdog: simulation did not finish"); $fatal; end

  initial begin
    logic [5:0] got;
    int n;
    bit hit;
    int s_fs, s_fe, s_err;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_acks", ackv, 0);
    check("rst_word_valid", word_valid, 0);
    check("rst_word_data", word_data, 0);
    check("rst_pulses", {frame_start, frame_end, frame_err}, 0);
    check("rst_in_frame", in_frame, 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);

    // Token->ack latency, rise and fall (X0 in idle has no side effects)
    raise(T_X);
    n = 0; hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(posedge clk); #1 n++;
      if (x0_ack) hit = 1;
    end
    check("lat_rise", n, 3);
    tok = '0;
    n = 0; hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(posedge clk); #1 n++;
      if (!x0_ack) hit = 1;
    end
    check("lat_fall", n, 3);
    repeat (2) @(negedge clk);

    // Table of single-token handshakes
    add(T_S, T_S, 1, 0, 0, 1'b1, 0, 8'h00);
    add_bits(8'hA5, 8);
    add(T_D, T_D, 0, 0, 0, 1'b1, 1, 8'hA5);
    add(T_E, T_E, 0, 1, 0, 1'b0, 0, 8'h00);
    add(T_S, T_S, 1, 0, 0, 1'b1, 0, 8'h00);
    add_bits(8'h19, 5);
    add(T_D, T_D, 0, 0, 1, 1'b1, 0, 8'h00);
    add_bits(8'h3C, 8);
    add(T_D, T_D, 0, 0, 0, 1'b1, 1, 8'h3C);
    add_bits(8'h01, 1);
    add(T_E, T_E, 0, 1, 1, 1'b0, 0, 8'h00);
    add(T_D, T_D, 0, 0, 1, 1'b0, 0, 8'h00);
    add(T_S, T_S, 1, 0, 0, 1'b1, 0, 8'h00);
    add(T_E | T_O, T_E, 0, 1, 1, 1'b0, 0, 8'h00);
    add(T_S, T_S, 1, 0, 0, 1'b1, 0, 8'h00);
    add_bits(8'h05, 3);
    add(T_X, T_X, 0, 0, 1, 1'b0, 0, 8'h00);
    add(T_X, T_X, 0, 0, 0, 1'b0, 0, 8'h00);
    add(T_S, T_S, 1, 0, 0, 1'b1, 0, 8'h00);
    add_bits(8'hC3, 8);
    add(T_O, T_O, 0, 0, 1, 1'b1, 0, 8'h00);
    add(T_D, T_D, 0, 0, 0, 1'b1, 1, 8'hC3);
    add(T_S, T_S, 1, 0, 1, 1'b1, 0, 8'h00);
    add(T_E, T_E, 0, 1, 0, 1'b0, 0, 8'h00);
    add(T_O, T_O, 0, 0, 1, 1'b0, 0, 8'h00);

    foreach (vt[k]) begin
      s_fs = c_fs; s_fe = c_fe; s_err = c_err;
      if (vt[k].push) exp_q.push_back(vt[k].word);
      hs(vt[k].tv, $sformatf("row%0d", k), got);
      check($sformatf("row%0d_ack", k), got, vt[k].ack);
      check($sformatf("row%0d_fs", k), c_fs - s_fs, vt[k].fs);
      check($sformatf("row%0d_fe", k), c_fe - s_fe, vt[k].fe);
      check($sformatf("row%0d_err", k), c_err - s_err, vt[k].err);
      check($sformatf("row%0d_in_frame", k), in_frame, vt[k].inf);
    end
    check("table_words_left", exp_q.size(), 0);

    // Backpressure: second delimiter held off until the first word is taken
    @(posedge clk); #1 word_ready = 1'b0;
    s_err = c_err;
    hs(T_S, "bp_s", got);
    for (int i = 7; i >= 0; i--) hs((8'h5A >> i) & 1 ? T_O : T_Z, "bp_b1", got);
    exp_q.push_back(8'h5A);
    hs(T_D, "bp_d1", got);
    repeat (20) @(negedge clk);
    check("bp_valid_held", word_valid, 1);
    check("bp_data_held", word_data, 8'h5A);
    for (int i = 7; i >= 0; i--) hs((8'h96 >> i) & 1 ? T_O : T_Z, "bp_b2", got);
    exp_q.push_back(8'h96);
    raise(T_D);
    repeat (10) @(negedge clk);
    check("bp_fd_ack_low", fd_ack, 0);
    check("bp_no_ack", ackv, 0);
    @(posedge clk); #1 word_ready = 1'b1;
    wait_ack("bp_d2", got);
    check("bp_d2_ack", got, T_D);
    release_tok("bp_d2");
    repeat (2) @(negedge clk);
    check("bp_words_left", exp_q.size(), 0);
    check("bp_err", c_err - s_err, 0);

    // Async reset while one_ack is high; token still high afterwards is fresh
    hs(T_S, "rs_s", got);
    raise(T_O);
    wait_ack("rs_o", got);
    check("rs_one_ack", got, T_O);
    #2 reset = 1'b0;
    #1;
    check("rs_acks", ackv, 0);
    check("rs_word_data", word_data, 0);
    check("rs_word_valid", word_valid, 0);
    check("rs_in_frame", in_frame, 0);
    check("rs_pulses", {frame_start, frame_end, frame_err}, 0);
    @(posedge clk); #1 reset = 1'b1;
    s_err = c_err;
    wait_ack("rs_fresh", got);
    check("rs_fresh_ack", got, T_O);
    release_tok("rs_fresh");
    check("rs_fresh_err", c_err - s_err, 1);
    check("rs_fresh_in_frame", in_frame, 0);

`ifdef RX_ACK_TIMEOUT_EN
    // Held token: ack must drop after TIMEOUT_CYC cycles with an error pulse
    s_err = c_err;
    raise(T_S);
    wait_ack("to_s", got);
    n = 1; hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (!fs_ack) hit = 1;
      else n++;
    end
    check("to_ack_cycles", n, TIMEOUT_CYC);
    @(posedge clk); #1 tok = '0;
    repeat (12) @(negedge clk);
    check("to_err", c_err - s_err, 1);
    check("to_ack_low", ackv, 0);
    hs(T_E, "to_close", got);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Clocked controller that sequences the self-timed dual-rail frame receiver. It synchronises the receiver's one-hot token outputs (frame start, frame end, delimiter, abort, zero, one) and closes each 4-phase handshake by driving the matching acknowledge. It assembles MSB-first bits into DATA_W-bit words for the clocked system, applying backpressure to the receiver by withholding acknowledges. It sits between the receiver and the synchronous packet logic.

## Interface
- DATA_W, 8, word width in bits (2..32)
- TIMEOUT_CYC, 1024, cycles an ack may stay high awaiting token release (only with RX_ACK_TIMEOUT_EN)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- fs_in, fe_in, fd_in, x0_in, zero_in, one_in  in  1 each  receiver tokens (asynchronous; frame start, frame end, word delimiter, abort, bit 0, bit 1)
- fs_ack, fe_ack, fd_ack, x0_ack, zero_ack, one_ack  out  1 each  registered acknowledges to receiver
- word_data  out  DATA_W  assembled word
- word_valid  out  1  word_data valid; held until word_ready
- word_ready  in  1  downstream accepts word
- frame_start, frame_end  out  1  single-cycle pulses
- frame_err  out  1  single-cycle pulse on any protocol error
- in_frame  out  1  high between accepted Fs and Fe/abort/error

## Operation
- All outputs 0 in reset, including word_data; bit counter 0; handshake FSM in H_IDLE; frame FSM in F_IDLE.
- Handshake FSM: H_IDLE -> H_ACK when any synchronised token is high and the token is acceptable (see backpressure); asserts exactly one ack. H_ACK -> H_REL when all synchronised tokens are low; ack drops. H_REL -> H_IDLE after one cycle.
- Simultaneous tokens: priority x0 > fe > fs > fd > one > zero; only the winner is acked/processed; frame_err pulses.
- Frame FSM: F_IDLE -> F_DATA on Fs (frame_start pulse, counter cleared). Tokens other than Fs in F_IDLE are acked and discarded; Fe/Fd/bits raise frame_err, X0 does not.
- F_DATA, bit: shift-left insert (MSB first), counter++. Bit at counter == DATA_W: acked, discarded, frame_err.
- F_DATA, Fd with counter == DATA_W: word loaded to word_data, word_valid set, counter cleared. Fd with any other count: word dropped, frame_err, counter cleared, frame stays open.
- F_DATA, Fe: frame_end pulse -> F_IDLE; partial bits discarded (frame_err if counter != 0).
- F_DATA, Fs: frame_err, restart (counter cleared, frame_start pulse).
- X0 anywhere in frame: abort -> F_IDLE, counter cleared, frame_err; pending word_valid is kept.
- Backpressure: while word_valid is high and word_ready is low, an Fd token is not acked (handshake stays H_IDLE). All other tokens proceed.
- word_valid clears the cycle after word_valid && word_ready; a new word may load in that same cycle.

## Timing
- Tokens pass a 2-flop synchroniser; acks are registered.
- Token rise -> ack rise: 3 clk. Token fall -> ack fall: 3 clk.
- Fd accepted -> word_valid high: same edge as fd_ack rise.
- frame_start/frame_end/frame_err: pulse on the edge where the corresponding ack rises.
- Async reset mid-handshake: acks drop immediately. Tokens still high after reset release are treated as fresh tokens.

## Configuration
- RX_ACK_TIMEOUT_EN defined: counter runs in H_ACK. When it reaches TIMEOUT_CYC: ack is forced low, frame_err pulses, frame FSM -> F_IDLE, handshake -> H_REL.
- Undefined: no counter; H_ACK waits indefinitely; TIMEOUT_CYC is ignored.

## Structure
- Package rx_frame_pkg holds:
  - token one-hot encoding and priority order;
  - handshake and frame state enums;
  - TOKEN_N = 6.
- Sub-module rx_sync2: parameterised-width 2-flop synchroniser with async active-low reset, applied to the 6-bit token vector.

## Test plan
- Fs, bits 1,0,1,0,0,1,0,1, Fd, Fe, with word_ready=1 -> word_data=0xA5, word_valid 1 cycle, frame_start and frame_end each one pulse, frame_err never.
- Fs, 8 bits, Fd with word_ready=0 for 20 cycles, then second word's Fd -> second fd_ack held low until word_ready; no word lost.
- Fs, 5 bits, Fd -> frame_err pulse, no word_valid, in_frame stays 1, next 8 bits + Fd gives a valid word.
- fe_in and one_in raised together -> only fe_ack asserted, frame_err pulse.
- Fs, 3 bits, X0 -> x0_ack, frame_err, in_frame=0; reset pulsed while one_ack high -> all outputs 0 asynchronously.
- RX_ACK_TIMEOUT_EN, TIMEOUT_CYC=16, token held high -> ack drops after 16 cycles, frame_err pulse.
